// File: rtl/uart_rx_ovs.sv
// UART receiver with 16x oversampling, 3-sample majority vote, optional parity, 1/2 stop bits
// and a fall-through receive FIFO presented through a valid/ready interface.
`timescale 1ns/1ps

module uart_rx_ovs #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rxd,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overrun,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int OVS_DIV = CLK_FREQ / (UART_BPS * 16);
  localparam int CNT_W   = $clog2(OVS_DIV);
  localparam int BC_W    = $clog2(DATA_BITS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENT_W   = DATA_BITS + 2;
  localparam logic ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2} state_t;

  state_t               state, state_next;
  logic                 rxd_meta, rxs, rxs_d;
  logic [1:0]           sync_vld;
  logic [CNT_W-1:0]     tick_cnt;
  logic [3:0]           phase;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 s7, s8, pe, fe, armed;
  logic                 tick, at_mid, at_end, maj, fe_final;
  logic                 start_det, frame_done;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, prev_ptr;
  logic                 pop, full, push_ok;
  logic [ENT_W-1:0]     head;

  // sync_vld marks when rxs reflects the real pad rather than the reset value,
  // so a line already low at reset release cannot look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
      rxs_d    <= 1'b1;
      sync_vld <= 2'b00;
    end else begin
      rxd_meta <= uart_rxd;
      rxs      <= rxd_meta;
      rxs_d    <= rxs;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign tick     = (tick_cnt == CNT_W'(OVS_DIV - 1));
  assign at_mid   = tick && (phase == 4'd9);
  assign at_end   = tick && (phase == 4'd15);
  assign maj      = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign fe_final = fe | ~maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (armed && rxs_d && !rxs) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (at_mid && maj)  state_next = IDLE;
        else if (at_end)    state_next = DATA;
      end
      DATA: begin
        if (at_end && (bit_cnt == BC_W'(DATA_BITS - 1)))
          state_next = (PARITY != 0) ? PAR : STOP1;
      end
      PAR: begin
        if (at_end) state_next = STOP1;
      end
      STOP1: begin
        if (at_mid && (STOP_BITS == 1)) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end else if (at_end) begin
          state_next = STOP2;
        end
      end
      STOP2: begin
        if (at_mid) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      pe       <= 1'b0;
      fe       <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (start_det || state == IDLE) begin
        tick_cnt <= '0;
        phase    <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        phase    <= phase + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
      if (start_det) begin
        bit_cnt <= '0;
        pe      <= 1'b0;
        fe      <= 1'b0;
      end
      if (tick && phase == 4'd7) s7 <= rxs;
      if (tick && phase == 4'd8) s8 <= rxs;
      if (state == DATA && at_mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == DATA && at_end) bit_cnt <= bit_cnt + BC_W'(1);
      if (state == PAR && at_mid) pe <= (maj != ((^shreg) ^ ODD));
      if ((state == STOP1 || state == STOP2) && at_mid && !maj) fe <= 1'b1;
      // A frame ending on a low stop bit (break) disarms until the line idles high.
      if (frame_done && fe_final)  armed <= 1'b0;
      else if (sync_vld[1] && rxs) armed <= 1'b1;
    end
  end

  assign rx_busy  = (state != IDLE);
  assign rx_valid = (rx_level != '0);
  assign pop      = rx_valid & rx_ready;
  assign full     = (rx_level == LVL_W'(FIFO_DEPTH));
  assign push_ok  = frame_done & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_level   <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      rx_overrun <= frame_done & full & ~pop;
      if (push_ok) begin
        mem[wr_ptr] <= {fe_final, pe, shreg};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   rx_level <= rx_level + LVL_W'(1);
        2'b01:   rx_level <= rx_level - LVL_W'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // When empty, the slot just behind rd_ptr still holds the last entry handed out.
  assign prev_ptr = rd_ptr - PTR_W'(1);
  assign head     = rx_valid ? mem[rd_ptr] : mem[prev_ptr];
  assign {rx_frame_err, rx_parity_err, rx_data} = head;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Randomised self-checking bench for uart_rx_ovs: three configurations driven from a frame-level
// reference model whose expected-entry queues are compared against the FIFO head every cycle.
`timescale 1ns/1ps

module tb_uart_rx_ovs;

  localparam int FAST_BPS = 781250;
  localparam int CFG_BITS  [3] = '{8, 7, 9};
  localparam int CFG_PAR   [3] = '{0, 2, 1};
  localparam int CFG_STOP  [3] = '{1, 2, 1};
  localparam int CFG_DEPTH [3] = '{4, 2, 4};
  localparam int CFG_CLKS  [3] = '{432, 64, 64};

  logic       clk, rst_n;
  logic       rxd [3];
  logic       rdy [3];
  logic       valid_o [3], pe_o [3], fe_o [3], ovr_o [3], busy_o [3];
  logic [8:0] data_o [3];
  int         level_o [3];

  logic [7:0] d0_data;
  logic [6:0] d1_data;
  logic [8:0] d2_data;
  logic [2:0] d0_level;
  logic [1:0] d1_level;
  logic [2:0] d2_level;

  logic [10:0] exp_q0 [$];
  logic [10:0] exp_q1 [$];
  logic [10:0] exp_q2 [$];
  logic [10:0] last_popped [3];
  bit          popped_any [3];
  int          prev_level [3], ovr_seen [3], last_push_cyc [3], last_mid_cyc [3];
  int          cyc, total, bad;
  bit          rnd_done;

  uart_rx_ovs u_dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_valid(valid_o[0]), .rx_ready(rdy[0]),
    .rx_data(d0_data), .rx_parity_err(pe_o[0]), .rx_frame_err(fe_o[0]), .rx_overrun(ovr_o[0]),
    .rx_busy(busy_o[0]), .rx_level(d0_level)
  );

  uart_rx_ovs #(.UART_BPS(FAST_BPS), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_valid(valid_o[1]), .rx_ready(rdy[1]),
    .rx_data(d1_data), .rx_parity_err(pe_o[1]), .rx_frame_err(fe_o[1]), .rx_overrun(ovr_o[1]),
    .rx_busy(busy_o[1]), .rx_level(d1_level)
  );

  uart_rx_ovs #(.UART_BPS(FAST_BPS), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_valid(valid_o[2]), .rx_ready(rdy[2]),
    .rx_data(d2_data), .rx_parity_err(pe_o[2]), .rx_frame_err(fe_o[2]), .rx_overrun(ovr_o[2]),
    .rx_busy(busy_o[2]), .rx_level(d2_level)
  );

  assign data_o[0]  = {1'b0, d0_data};
  assign data_o[1]  = {2'b00, d1_data};
  assign data_o[2]  = d2_data;
  assign level_o[0] = int'(d0_level);
  assign level_o[1] = int'(d1_level);
  assign level_o[2] = int'(d2_level);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] mk(bit fe, bit pe, logic [8:0] data);
    return {fe, pe, data};
  endfunction

  function automatic void push_exp(int d, logic [10:0] e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endfunction

  function automatic int exp_size(int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [10:0] exp_front(int d);
    case (d)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic logic [10:0] exp_pop(int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic checkOutput(string name, int d, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL dut%0d %s: got=0x%0h want=0x%0h (t=%0t)", d, name, act, req, $time);
    end
  endtask

  task automatic waitClk(int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame and appends its expected FIFO entry to the model when keep is set.
  task automatic applyStimulus(int d, logic [8:0] data, bit bad_par, bit bad_s1, bit bad_s2,
                               int gap_bits, bit keep);
    int         nb   = CFG_BITS[d];
    int         clks = CFG_CLKS[d];
    logic [8:0] m    = data & 9'((1 << nb) - 1);
    bit         p    = (^m) ^ (CFG_PAR[d] == 1) ^ bad_par;
    bit         fe   = bad_s1 | ((CFG_STOP[d] == 2) && bad_s2);
    if (keep) push_exp(d, mk(fe, (CFG_PAR[d] != 0) && bad_par, m));
    rxd[d] = 1'b0;
    waitClk(clks);
    for (int i = 0; i < nb; i++) begin
      rxd[d] = m[i];
      waitClk(clks);
    end
    if (CFG_PAR[d] != 0) begin
      rxd[d] = p;
      waitClk(clks);
    end
    if (CFG_STOP[d] == 2) begin
      rxd[d] = !bad_s1;
      waitClk(clks);
    end
    last_mid_cyc[d] = cyc + clks / 2;
    rxd[d] = (CFG_STOP[d] == 2) ? !bad_s2 : !bad_s1;
    waitClk(clks);
    rxd[d] = 1'b1;
    waitClk(clks * gap_bits);
  endtask

  task automatic waitDrain(int d);
    int n = 0;
    while (exp_size(d) != 0 && n < 6000) begin
      waitClk(1);
      n++;
    end
    checkOutput("drain_left", d, exp_size(d), 0);
  endtask

  task automatic randomFrames(int d, int count);
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < count; k++) begin
          bit bp = ($urandom_range(0, 3) == 0);
          bit b1 = ($urandom_range(0, 5) == 0);
          bit b2 = (CFG_STOP[d] == 2) && ($urandom_range(0, 5) == 0);
          int gap = (b1 || b2) ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
          applyStimulus(d, 9'($urandom), bp, b1, b2, gap, 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rdy[d] = 1'($urandom_range(0, 1));
          waitClk(1);
        end
      end
    join
    rdy[d] = 1'b1;
    waitDrain(d);
  endtask

  // Every cycle a head is presented it must match the oldest outstanding expected entry;
  // when empty the outputs must keep showing the entry popped last.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        popped_any[d] = 1'b0;
        prev_level[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        logic [10:0] got;
        got = {fe_o[d], pe_o[d], data_o[d]};
        if (level_o[d] > prev_level[d]) last_push_cyc[d] = cyc;
        prev_level[d] = level_o[d];
        if (ovr_o[d]) ovr_seen[d]++;
        if (valid_o[d]) begin
          if (exp_size(d) == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL dut%0d unexpected_entry: got=0x%0h want=none (t=%0t)", d, got, $time);
          end else begin
            checkOutput("head", d, got, exp_front(d));
            if (rdy[d]) begin
              last_popped[d] = exp_pop(d);
              popped_any[d]  = 1'b1;
            end
          end
        end else if (popped_any[d]) begin
          checkOutput("hold", d, got, last_popped[d]);
        end
      end
    end
  end

  initial begin
    cyc = 0; total = 0; bad = 0; rnd_done = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rxd[d] = 1'b1;
      rdy[d] = 1'b1;
      ovr_seen[d] = 0;
      last_push_cyc[d] = 0;
      last_mid_cyc[d] = 0;
    end
    waitClk(5);
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_valid", d, valid_o[d], 0);
      checkOutput("rst_level", d, level_o[d], 0);
      checkOutput("rst_busy", d, busy_o[d], 0);
      checkOutput("rst_data", d, {fe_o[d], pe_o[d], data_o[d]}, 0);
      checkOutput("rst_overrun", d, ovr_o[d], 0);
    end
    rst_n = 1'b1;
    waitClk(5);

    $display("[TB] 8N1 frames 0x55, 0xA3");
    applyStimulus(0, 9'h55, 0, 0, 0, 1, 1);
    checkOutput("latency_55", 0, (last_push_cyc[0] > last_mid_cyc[0]) &&
                (last_push_cyc[0] <= last_mid_cyc[0] + CFG_CLKS[0] + 10), 1);
    applyStimulus(0, 9'hA3, 0, 0, 0, 1, 1);
    checkOutput("latency_a3", 0, (last_push_cyc[0] > last_mid_cyc[0]) &&
                (last_push_cyc[0] <= last_mid_cyc[0] + CFG_CLKS[0] + 10), 1);
    waitDrain(0);
    checkOutput("t1_last_data", 0, data_o[0], 9'h0A3);
    checkOutput("t1_last_flags", 0, {fe_o[0], pe_o[0]}, 2'b00);

    $display("[TB] 7E2 parity good and flipped");
    applyStimulus(1, 9'h03A, 0, 0, 0, 1, 1);
    applyStimulus(1, 9'h03A, 1, 0, 0, 1, 1);
    waitDrain(1);
    checkOutput("t2_last_data", 1, data_o[1], 9'h03A);
    checkOutput("t2_last_pe", 1, pe_o[1], 1);
    checkOutput("t2_last_fe", 1, fe_o[1], 0);

    $display("[TB] framing error, break, recovery");
    applyStimulus(0, 9'h0F0, 0, 1, 0, 1, 1);
    push_exp(0, mk(1'b1, 1'b0, 9'h000));
    rxd[0] = 1'b0;
    waitClk(20 * CFG_CLKS[0]);
    checkOutput("break_busy", 0, busy_o[0], 0);
    rxd[0] = 1'b1;
    waitClk(2 * CFG_CLKS[0]);
    applyStimulus(0, 9'h012, 0, 0, 0, 1, 1);
    waitDrain(0);
    checkOutput("t3_last_data", 0, data_o[0], 9'h012);
    checkOutput("t3_last_fe", 0, fe_o[0], 0);

    $display("[TB] quarter-bit glitch");
    rxd[0] = 1'b0;
    waitClk(60);
    checkOutput("glitch_busy_hi", 0, busy_o[0], 1);
    waitClk(48);
    rxd[0] = 1'b1;
    waitClk(172);
    checkOutput("glitch_busy_lo", 0, busy_o[0], 0);
    waitClk(CFG_CLKS[0]);
    checkOutput("glitch_level", 0, level_o[0], 0);

    $display("[TB] overrun with consumer stalled");
    rdy[2] = 1'b0;
    for (int v = 1; v <= 5; v++)
      applyStimulus(2, 9'(v), 0, 0, 0, 1, (v - 1) < CFG_DEPTH[2]);
    checkOutput("ovr_level", 2, level_o[2], CFG_DEPTH[2]);
    checkOutput("ovr_pulses", 2, ovr_seen[2], 1);
    rdy[2] = 1'b1;
    waitDrain(2);
    checkOutput("ovr_last_data", 2, data_o[2], 9'h004);

    $display("[TB] reset mid-frame");
    rdy[0] = 1'b0;
    applyStimulus(0, 9'h03C, 0, 0, 0, 1, 1);
    rxd[0] = 1'b0;
    waitClk(CFG_CLKS[0] + 200);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    waitClk(3);
    checkOutput("mid_rst_valid", 0, valid_o[0], 0);
    checkOutput("mid_rst_level", 0, level_o[0], 0);
    checkOutput("mid_rst_busy", 0, busy_o[0], 0);
    checkOutput("mid_rst_data", 0, {fe_o[0], pe_o[0], data_o[0]}, 0);
    rst_n = 1'b1;
    waitClk(2 * CFG_CLKS[0]);
    checkOutput("low_line_busy", 0, busy_o[0], 0);
    checkOutput("low_line_level", 0, level_o[0], 0);
    rxd[0] = 1'b1;
    rdy[0] = 1'b1;
    waitClk(CFG_CLKS[0]);
    applyStimulus(0, 9'h07E, 0, 0, 0, 1, 1);
    waitDrain(0);
    checkOutput("t6_last_data", 0, data_o[0], 9'h07E);

    $display("[TB] randomised frames");
    randomFrames(1, 12);
    randomFrames(2, 12);

    checkOutput("no_ovr_dut0", 0, ovr_seen[0], 0);
    checkOutput("no_ovr_dut1", 1, ovr_seen[1], 0);
    checkOutput("ovr_total_dut2", 2, ovr_seen[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
